// File: rtl/pixel_frame_writer.sv
// Pixel write path: handshake FIFO, bank decode stage, five banked RAMs,
// registered readback and frame tracking. Optional range check: PIXEL_WR_BOUNDS_CHECK_EN.
module pixel_frame_writer #(
  parameter int DEPTH        = 4,
  parameter int BANK_SIZE    = 65000,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [18:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [18:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic [18:0] pix_count,
  output logic        frame_done,
  output logic        err
);

  localparam int PW      = $clog2(DEPTH);
  localparam int PTR_W   = PW + 1;
  localparam int B4_SIZE = FRAME_PIXELS - 4 * BANK_SIZE;
  localparam int BI      = $clog2(BANK_SIZE);
  localparam int B4I     = $clog2(B4_SIZE);

  localparam logic [18:0] B1      = 19'(BANK_SIZE);
  localparam logic [18:0] B2      = 19'(2 * BANK_SIZE);
  localparam logic [18:0] B3      = 19'(3 * BANK_SIZE);
  localparam logic [18:0] B4      = 19'(4 * BANK_SIZE);
  localparam logic [18:0] FRAME_L = 19'(FRAME_PIXELS);
  localparam logic [18:0] LAST    = 19'(FRAME_PIXELS - 1);
  localparam logic [16:0] B4_LIM  = 17'(B4_SIZE);

  function automatic logic [2:0] bank_of(input logic [18:0] a);
    if (a < B1)      return 3'd0;
    else if (a < B2) return 3'd1;
    else if (a < B3) return 3'd2;
    else if (a < B4) return 3'd3;
    else             return 3'd4;
  endfunction

  function automatic logic [16:0] offset_of(input logic [18:0] a, input logic [2:0] b);
    logic [18:0] base;
    case (b)
      3'd0:    base = 19'd0;
      3'd1:    base = B1;
      3'd2:    base = B2;
      3'd3:    base = B3;
      default: base = B4;
    endcase
    return 17'(a - base);
  endfunction

  // Held low in the design; gives the bench a way to stall the drain.
  logic pop_stall;
  assign pop_stall = 1'b0;

  logic [18:0]      fifo_addr [DEPTH];
  logic [7:0]       fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic [18:0]      head_addr;
  logic [7:0]       head_data;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign wr_ready  = !full && !rst;
  assign push      = wr_valid && wr_ready;
  assign pop       = !empty && !pop_stall;
  assign head_addr = fifo_addr[rd_ptr[PW-1:0]];
  assign head_data = fifo_data[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= wr_addr;
      fifo_data[wr_ptr[PW-1:0]] <= wr_data;
    end
  end

  // ---- stage D: bank decode of the FIFO head ----
  logic        vld_p0;
  logic [2:0]  bank_p0;
  logic [16:0] offset_p0;
  logic [7:0]  data_p0;

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= pop;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      bank_p0   <= bank_of(head_addr);
      offset_p0 <= offset_of(head_addr, bank_of(head_addr));
      data_p0   <= head_data;
    end
  end

  // ---- stage C: RAM commit and frame accounting ----
  logic bank_ok_p0, count_p0, wr_en_p0;
  assign bank_ok_p0 = (bank_p0 != 3'd4) || (offset_p0 < B4_LIM);

`ifdef PIXEL_WR_BOUNDS_CHECK_EN
  logic oob_p0;
  always_ff @(posedge clk) begin
    if (pop) oob_p0 <= (head_addr >= FRAME_L);
  end
  assign count_p0 = vld_p0 && !oob_p0 && !rst;

  always_ff @(posedge clk) begin
    if (rst)                  err <= 1'b0;
    else if (vld_p0 && oob_p0) err <= 1'b1;
  end
`else
  assign count_p0 = vld_p0 && !rst;
  assign err      = 1'b0;
`endif

  assign wr_en_p0 = count_p0 && bank_ok_p0;
  assign busy     = !empty || vld_p0;

  logic [7:0] mem0 [BANK_SIZE];
  logic [7:0] mem1 [BANK_SIZE];
  logic [7:0] mem2 [BANK_SIZE];
  logic [7:0] mem3 [BANK_SIZE];
  logic [7:0] mem4 [B4_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en_p0) begin
      case (bank_p0)
        3'd0:    mem0[BI'(offset_p0)]  <= data_p0;
        3'd1:    mem1[BI'(offset_p0)]  <= data_p0;
        3'd2:    mem2[BI'(offset_p0)]  <= data_p0;
        3'd3:    mem3[BI'(offset_p0)]  <= data_p0;
        default: mem4[B4I'(offset_p0)] <= data_p0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (count_p0) begin
        if (pix_count == LAST) begin
          pix_count  <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_count <= pix_count + 19'd1;
        end
      end
    end
  end

  // Readback: same decode, registered; a same-cycle commit is not visible yet.
  logic [2:0]  rd_bank;
  logic [16:0] rd_off;
  logic [7:0]  rd_pix;

  always_comb begin
    rd_bank = bank_of(rd_addr);
    rd_off  = offset_of(rd_addr, rd_bank);
    rd_pix  = 8'd0;
    if (rd_addr < FRAME_L) begin
      case (rd_bank)
        3'd0:    rd_pix = mem0[BI'(rd_off)];
        3'd1:    rd_pix = mem1[BI'(rd_off)];
        3'd2:    rd_pix = mem2[BI'(rd_off)];
        3'd3:    rd_pix = mem3[BI'(rd_off)];
        default: rd_pix = mem4[B4I'(rd_off)];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= {24'd0, rd_pix};
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer: full-size instance for banking and
// handshake behaviour, reduced-frame instance for frame wrap.
module tb_pixel_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic [18:0] rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic [18:0] pix_count;
  logic        frame_done;
  logic        err;

  logic        s_wr_valid;
  logic        s_wr_ready;
  logic [18:0] s_wr_addr;
  logic [7:0]  s_wr_data;
  logic [18:0] s_rd_addr;
  logic [31:0] s_rd_data;
  logic        s_busy;
  logic [18:0] s_pix_count;
  logic        s_frame_done;
  logic        s_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pixel_frame_writer u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .pix_count(pix_count), .frame_done(frame_done), .err(err)
  );

  pixel_frame_writer #(.DEPTH(4), .BANK_SIZE(4), .FRAME_PIXELS(20)) u_small (
    .clk(clk), .rst(rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .busy(s_busy), .pix_count(s_pix_count), .frame_done(s_frame_done), .err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [18:0] a, input logic [7:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic rb(input string tag, input logic [18:0] a, input logic [31:0] exp);
    rd_addr = a;
    tick();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int fd_cnt;
    int fd_iter;
    int rdy_low;
    logic r;

    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    s_wr_valid = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pix_count", {13'd0, pix_count}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, wr_ready}, 32'd1);

    // Single write with latency checks
    wr_valid = 1'b1; wr_addr = 19'd0; wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0;
    chk("lat_n_busy", {31'd0, busy}, 32'd1);
    chk("lat_n_count", {13'd0, pix_count}, 32'd0);
    tick();
    chk("lat_n1_count", {13'd0, pix_count}, 32'd0);
    tick();
    chk("lat_n2_count", {13'd0, pix_count}, 32'd1);
    chk("lat_n2_busy", {31'd0, busy}, 32'd0);
    rb("rd_addr0", 19'd0, 32'h0000_00A5);

    // Bank boundaries, neighbours written first
    send(19'd64998, 8'h61);
    send(19'd65001, 8'h62);
    send(19'd259998, 8'h63);
    send(19'd260001, 8'h64);
    send(19'd307198, 8'h65);
    send(19'd64999, 8'h11);
    send(19'd65000, 8'h22);
    send(19'd259999, 8'h33);
    send(19'd260000, 8'h44);
    send(19'd307199, 8'h55);
    drain();
    rb("rd_64999", 19'd64999, 32'h11);
    rb("rd_65000", 19'd65000, 32'h22);
    rb("rd_259999", 19'd259999, 32'h33);
    rb("rd_260000", 19'd260000, 32'h44);
    rb("rd_307199", 19'd307199, 32'h55);
    rb("rd_64998", 19'd64998, 32'h61);
    rb("rd_65001", 19'd65001, 32'h62);
    rb("rd_259998", 19'd259998, 32'h63);
    rb("rd_260001", 19'd260001, 32'h64);
    rb("rd_307198", 19'd307198, 32'h65);
    rb("rd_307200_zero", 19'd307200, 32'd0);
    rb("rd_400000_zero", 19'd400000, 32'd0);
    chk("count_after_banks", {13'd0, pix_count}, 32'd11);

    // Read and commit to the same address on the same edge
    send(19'd100, 8'h10);
    drain();
    wr_valid = 1'b1; wr_addr = 19'd100; wr_data = 8'h20; rd_addr = 19'd100;
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    chk("rw_same_old", rd_data, 32'h10);
    tick();
    chk("rw_same_new", rd_data, 32'h20);

    // Backpressure with drain stalled
    force u_dut.pop_stall = 1'b1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      wr_valid = (idx < 6);
      wr_addr  = 19'(1000 + idx);
      wr_data  = 8'(8'hB0 + idx);
      r = wr_ready;
      tick();
      if (r && idx < 6) idx++;
    end
    chk("bp_accepted", idx, 32'd4);
    chk("bp_ready_low", {31'd0, wr_ready}, 32'd0);
    release u_dut.pop_stall;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      wr_valid = 1'b1;
      wr_addr  = 19'(1000 + idx);
      wr_data  = 8'(8'hB0 + idx);
      r = wr_ready;
      tick();
      if (r) idx++;
    end
    wr_valid = 1'b0;
    chk("bp_all_sent", idx, 32'd6);
    drain();
    for (int i = 0; i < 6; i++) rb("bp_readback", 19'(1000 + i), 32'(8'hB0 + i));
    chk("count_after_bp", {13'd0, pix_count}, 32'd19);

    // Reset with three pixels in flight
    send(19'd2000, 8'h01);
    send(19'd2001, 8'h02);
    send(19'd2002, 8'h03);
    drain();
    chk("count_before_rst", {13'd0, pix_count}, 32'd22);
    force u_dut.pop_stall = 1'b1;
    send(19'd2000, 8'hC0);
    send(19'd2001, 8'hC1);
    send(19'd2002, 8'hC2);
    chk("inflight_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    release u_dut.pop_stall;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_count", {13'd0, pix_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
    repeat (5) tick();
    chk("mid_rst_count_later", {13'd0, pix_count}, 32'd0);
    rb("keep_2000", 19'd2000, 32'h01);
    rb("keep_2001", 19'd2001, 32'h02);
    rb("keep_2002", 19'd2002, 32'h03);
    rb("keep_0", 19'd0, 32'hA5);

    // Out-of-range write
    send(19'd307300, 8'hFF);
    drain();
`ifdef PIXEL_WR_BOUNDS_CHECK_EN
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_count", {13'd0, pix_count}, 32'd0);
`else
    chk("oor_err", {31'd0, err}, 32'd0);
    chk("oor_count", {13'd0, pix_count}, 32'd1);
`endif
    rb("oor_bank4_last", 19'd307199, 32'h55);
    rb("oor_bank4_prev", 19'd307198, 32'h65);
    rb("oor_rd_zero", 19'd307300, 32'd0);

    // Frame wrap on the 20-pixel instance, continuous streaming
    fd_cnt = 0; fd_iter = -1; rdy_low = 0;
    for (int k = 0; k < 30; k++) begin
      s_wr_valid = (k < 20);
      s_wr_addr  = 19'(k);
      s_wr_data  = 8'(8'h40 + k);
      if (k < 20 && !s_wr_ready) rdy_low++;
      tick();
      if (s_frame_done) begin
        fd_cnt++;
        fd_iter = k;
      end
      if (k == 20) begin
        chk("wrap_count_pre", {13'd0, s_pix_count}, 32'd19);
        chk("wrap_busy_pre", {31'd0, s_busy}, 32'd1);
      end
      if (k == 21) begin
        chk("wrap_count_post", {13'd0, s_pix_count}, 32'd0);
        chk("wrap_busy_post", {31'd0, s_busy}, 32'd0);
      end
    end
    s_wr_valid = 1'b0;
    chk("wrap_ready_low_cycles", rdy_low, 32'd0);
    chk("wrap_done_pulses", fd_cnt, 32'd1);
    chk("wrap_done_cycle", fd_iter, 32'd21);
    chk("wrap_count_final", {13'd0, s_pix_count}, 32'd0);
    s_rd_addr = 19'd19;
    tick();
    chk("wrap_rd_19", s_rd_data, 32'h53);
    s_rd_addr = 19'd4;
    tick();
    chk("wrap_rd_4", s_rd_data, 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
